acumulador_multi: RTL and testbench
===================================

ACUMULADOR_MULTI -- requirements
Module: acumulador_multi

Interface
REQ-001 Parameter WIDTH, default 16, data width of input, staging registers and accumulators.
REQ-002 Parameter CHANNELS, default 4, number of independent accumulator channels (2..16).
REQ-003 Parameter SATURATE, default 0, overflow mode: 0 = wrap, 1 = clamp.
REQ-004 Derived CW = ceil(log2(CHANNELS)), channel index width.
REQ-005 clk  in  1  single clock; all state updates on its falling edge.
REQ-006 clear  in  1  asynchronous, active-low reset of all state.
REQ-007 in  in  WIDTH  unsigned operand to stage.
REQ-008 ch  in  CW  target channel for load, transf, sub, clr_ch.
REQ-009 load  in  1  stage in into r_in[ch].
REQ-010 transf  in  1  accumulate r_in[ch] into acc[ch].
REQ-011 sub  in  1  with transf: subtract instead of add.
REQ-012 clr_ch  in  1  synchronous clear of acc[ch] and ovf[ch].
REQ-013 rd_ch  in  CW  channel driven on out.
REQ-014 out  out  WIDTH  acc[rd_ch], combinational mux of registered values.
REQ-015 ovf  out  CHANNELS  per-channel sticky overflow/underflow flags.
REQ-016 done  out  1  registered one-cycle pulse after an accepted transf.

Function
REQ-017 All registers SHALL update only on the falling edge of clk, except asynchronous clear.
REQ-018 load=1 SHALL capture in into r_in[ch]; other channels' r_in hold.
REQ-019 transf=1, sub=0 SHALL compute acc[ch]+r_in[ch] at WIDTH+1 bits; sub=1 SHALL compute acc[ch]-r_in[ch] at WIDTH+1 bits.
REQ-020 load and transf on the same edge, same channel: transf SHALL use the r_in value held before that edge; new value visible from the next edge.
REQ-021 SATURATE=0: acc[ch] SHALL take the low WIDTH bits of the result (modulo 2^WIDTH).
REQ-022 SATURATE=1: addition carry SHALL clamp acc[ch] to 2^WIDTH-1; subtraction borrow SHALL clamp acc[ch] to 0.
REQ-023 Carry (add) or borrow (sub) SHALL set ovf[ch]=1 in both modes; ovf[ch] stays set until clr_ch on that channel or clear.
REQ-024 clr_ch=1 SHALL set acc[ch]=0 and ovf[ch]=0, taking priority over transf on the same edge; r_in[ch] unaffected; load on the same edge still takes effect.
REQ-025 ch >= CHANNELS SHALL make load, transf, clr_ch no-ops; done SHALL not pulse.
REQ-026 done SHALL be 1 for exactly the clk period following an edge where transf=1, clr_ch=0, ch valid; back-to-back transfs SHALL keep done high continuously.
REQ-027 Channels without activity SHALL hold acc, r_in, ovf unchanged.
REQ-028 out SHALL equal acc[rd_ch]; rd_ch >= CHANNELS SHALL drive out=0.
REQ-029 Updated acc[ch] SHALL appear on out (when rd_ch=ch) immediately after the updating edge; latency one edge.

Reset
REQ-030 clear=0 SHALL immediately force every r_in, acc, ovf bit and done to 0, independent of clk.
REQ-031 clear deasserting SHALL take effect without glitching state; first update occurs on the next falling edge with clear=1.
REQ-032 clear asserted mid-sequence SHALL discard all staged and accumulated values; no done pulse SHALL follow.

Verification
REQ-033 Defaults; load in=5 ch=1, then transf ch=1 three times -> out(rd_ch=1)=15, done high 3 cycles, ovf=0000, other channels 0.
REQ-034 Wrap: acc[0]=0xFFF0, r_in[0]=0x0020, transf -> acc[0]=0x0010, ovf[0]=1; then sub with r_in=0x0020 -> acc[0]=0xFFF0, ovf[0] stays 1.
REQ-035 SATURATE=1: same stimulus -> acc[0]=0xFFFF, ovf[0]=1; acc=3 minus 5 -> acc=0, ovf set.
REQ-036 Same edge load in=9 and transf ch=2 with r_in[2]=4, acc[2]=0 -> acc[2]=4; next transf -> 13.
REQ-037 clr_ch with transf ch=3, acc[3]=7 -> acc[3]=0, ovf[3]=0, done stays 0; ch=5 with CHANNELS=4 -> no state change.
REQ-038 clear pulsed low between clk edges with acc nonzero -> out=0, ovf=0, done=0 immediately; next transf without load adds 0.

Source files
------------

// File: rtl/acumulador_multi.sv
// rtl/acumulador_multi.sv - multi-channel staged accumulator, falling-edge clocked
// Per-channel staging register feeds a wrap/clamp accumulator with sticky overflow flags.
module acumulador_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [WIDTH-1:0]    in,
  input  logic [CW-1:0]       ch,
  input  logic                load,
  input  logic                transf,
  input  logic                sub,
  input  logic                clr_ch,
  input  logic [CW-1:0]       rd_ch,
  output logic [WIDTH-1:0]    out,
  output logic [CHANNELS-1:0] ovf,
  output logic                done
);

  logic [WIDTH-1:0]    r_in_q [CHANNELS];
  logic [WIDTH-1:0]    r_in_d [CHANNELS];
  logic [WIDTH-1:0]    acc_q  [CHANNELS];
  logic [WIDTH-1:0]    acc_d  [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [WIDTH:0]      sum;

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_in_q[i] <= '0;
        acc_q[i]  <= '0;
      end
      ovf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_in_q[i] <= r_in_d[i];
        acc_q[i]  <= acc_d[i];
      end
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // Only a channel whose index matches ch is touched, so out-of-range ch is a no-op.
  always_comb begin
    r_in_d = r_in_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    sum    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CW'(i)) begin
        // The extra MSB of sum is the carry on add and the borrow on subtract.
        sum = sub ? ({1'b0, acc_q[i]} - {1'b0, r_in_q[i]})
                  : ({1'b0, acc_q[i]} + {1'b0, r_in_q[i]});
        if (load) begin
          r_in_d[i] = in;
        end
        if (clr_ch) begin
          acc_d[i] = '0;
          ovf_d[i] = 1'b0;
        end else if (transf) begin
          done_d = 1'b1;
          if (sum[WIDTH]) begin
            ovf_d[i] = 1'b1;
            if (SATURATE != 0) begin
              acc_d[i] = sub ? '0 : '1;
            end else begin
              acc_d[i] = sum[WIDTH-1:0];
            end
          end else begin
            acc_d[i] = sum[WIDTH-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch == CW'(i)) begin
        out = acc_q[i];
      end
    end
  end

  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_acumulador_multi.sv
// tb/tb_acumulador_multi.sv - self-checking bench for acumulador_multi
// dut0: 4 channels, wrap; dut1: 3 channels, clamp (ch=3 is out of range there).
module tb_acumulador_multi;

  logic        clk, clear;
  logic [15:0] in;
  logic [1:0]  ch, rd_ch;
  logic        load, transf, sub, clr_ch;
  logic [15:0] out0, out1;
  logic [3:0]  ovf0;
  logic [2:0]  ovf1;
  logic        done0, done1;

  int errors = 0;
  int checks = 0;

  int m_rin [2][4];
  int m_acc [2][4];
  bit m_ovf [2][4];
  bit m_done [2];
  int chans [2] = '{4, 3};
  int sat   [2] = '{0, 1};

  acumulador_multi #(.WIDTH(16), .CHANNELS(4), .SATURATE(0)) dut0 (
    .clk(clk), .clear(clear), .in(in), .ch(ch), .load(load), .transf(transf),
    .sub(sub), .clr_ch(clr_ch), .rd_ch(rd_ch), .out(out0), .ovf(ovf0), .done(done0)
  );

  acumulador_multi #(.WIDTH(16), .CHANNELS(3), .SATURATE(1)) dut1 (
    .clk(clk), .clear(clear), .in(in), .ch(ch), .load(load), .transf(transf),
    .sub(sub), .clr_ch(clr_ch), .rd_ch(rd_ch), .out(out1), .ovf(ovf1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_rin[d][c] = 0;
        m_acc[d][c] = 0;
        m_ovf[d][c] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0;
      if (int'(ch) < chans[d]) begin
        int c   = int'(ch);
        int old = m_rin[d][c];
        int r;
        if (clr_ch) begin
          m_acc[d][c] = 0;
          m_ovf[d][c] = 1'b0;
        end else if (transf) begin
          r = sub ? m_acc[d][c] - old : m_acc[d][c] + old;
          if (r < 0 || r > 65535) begin
            m_ovf[d][c] = 1'b1;
            if (sat[d] != 0) r = (r < 0) ? 0 : 65535;
            else r = r & 32'hFFFF;
          end
          m_acc[d][c] = r;
          m_done[d] = 1'b1;
        end
        if (load) m_rin[d][c] = int'(in);
      end
    end
  endtask

  function automatic logic [15:0] exp_out(int d, int rd);
    return (rd < chans[d]) ? 16'(m_acc[d][rd]) : 16'h0;
  endfunction

  function automatic logic [3:0] exp_ovf(int d);
    logic [3:0] v = '0;
    for (int c = 0; c < chans[d]; c++) v[c] = m_ovf[d][c];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (clear) model_edge();
    #1;
    load = 0; transf = 0; sub = 0; clr_ch = 0;
  endtask

  task automatic test_reset();
    clear = 0; in = 0; ch = 0; rd_ch = 0;
    load = 0; transf = 0; sub = 0; clr_ch = 0;
    model_reset();
    #3;
    for (int rd = 0; rd < 4; rd++) begin
      rd_ch = 2'(rd); #0.5;
      checks += 2;
      if (out0 !== 16'h0) begin errors++; $display("FAIL reset_out0[%0d] got=%h exp=0000", rd, out0); end
      if (out1 !== 16'h0) begin errors++; $display("FAIL reset_out1[%0d] got=%h exp=0000", rd, out1); end
    end
    checks += 2;
    if ({ovf1, ovf0} !== 7'h0) begin errors++; $display("FAIL reset_ovf got=%b_%b exp=0", ovf1, ovf0); end
    if ({done1, done0} !== 2'b00) begin errors++; $display("FAIL reset_done got=%b%b exp=00", done1, done0); end
    #2 clear = 1;
  endtask

  task automatic test_basic();
    ch = 1; in = 16'd5; load = 1; tick();
    for (int k = 0; k < 3; k++) begin
      ch = 1; transf = 1; tick();
      checks += 2;
      if (done0 !== 1'b1) begin errors++; $display("FAIL basic_done0 cyc%0d got=%b exp=1", k, done0); end
      if (done1 !== 1'b1) begin errors++; $display("FAIL basic_done1 cyc%0d got=%b exp=1", k, done1); end
    end
    rd_ch = 1; #0.5;
    checks += 3;
    if (out0 !== 16'd15) begin errors++; $display("FAIL basic_out0 got=%0d exp=15", out0); end
    if (out1 !== 16'd15) begin errors++; $display("FAIL basic_out1 got=%0d exp=15", out1); end
    if (ovf0 !== 4'b0000) begin errors++; $display("FAIL basic_ovf0 got=%b exp=0000", ovf0); end
    for (int rd = 0; rd < 4; rd++) begin
      rd_ch = 2'(rd); #0.5;
      checks += 2;
      if (out0 !== exp_out(0, rd)) begin errors++; $display("FAIL basic_sweep0[%0d] got=%h exp=%h", rd, out0, exp_out(0, rd)); end
      if (out1 !== exp_out(1, rd)) begin errors++; $display("FAIL basic_sweep1[%0d] got=%h exp=%h", rd, out1, exp_out(1, rd)); end
    end
    tick();
    checks += 1;
    if ({done1, done0} !== 2'b00) begin errors++; $display("FAIL basic_done_end got=%b%b exp=00", done1, done0); end
  endtask

  task automatic test_wrap_and_clamp();
    ch = 0; clr_ch = 1; in = 16'hFFF0; load = 1; tick();
    ch = 0; transf = 1; tick();
    ch = 0; in = 16'h0020; load = 1; tick();
    ch = 0; transf = 1; tick();
    rd_ch = 0; #0.5;
    checks += 4;
    if (out0 !== 16'h0010) begin errors++; $display("FAIL wrap_add_out0 got=%h exp=0010", out0); end
    if (out1 !== 16'hFFFF) begin errors++; $display("FAIL clamp_add_out1 got=%h exp=ffff", out1); end
    if (ovf0[0] !== 1'b1) begin errors++; $display("FAIL wrap_add_ovf0 got=%b exp=1", ovf0[0]); end
    if (ovf1[0] !== 1'b1) begin errors++; $display("FAIL clamp_add_ovf1 got=%b exp=1", ovf1[0]); end
    ch = 0; transf = 1; sub = 1; tick();
    rd_ch = 0; #0.5;
    checks += 2;
    if (out0 !== 16'hFFF0) begin errors++; $display("FAIL wrap_sub_out0 got=%h exp=fff0", out0); end
    if (ovf0[0] !== 1'b1) begin errors++; $display("FAIL wrap_sub_ovf_sticky got=%b exp=1", ovf0[0]); end
    ch = 0; clr_ch = 1; in = 16'd3; load = 1; tick();
    ch = 0; transf = 1; tick();
    ch = 0; in = 16'd5; load = 1; tick();
    ch = 0; transf = 1; sub = 1; tick();
    rd_ch = 0; #0.5;
    checks += 3;
    if (out1 !== 16'h0000) begin errors++; $display("FAIL clamp_sub_out1 got=%h exp=0000", out1); end
    if (ovf1[0] !== 1'b1) begin errors++; $display("FAIL clamp_sub_ovf1 got=%b exp=1", ovf1[0]); end
    if (out0 !== 16'hFFFE) begin errors++; $display("FAIL wrap_borrow_out0 got=%h exp=fffe", out0); end
    checks += 2;
    if (ovf0 !== exp_ovf(0)) begin errors++; $display("FAIL wrap_ovf0_vec got=%b exp=%b", ovf0, exp_ovf(0)); end
    if ({1'b0, ovf1} !== exp_ovf(1)) begin errors++; $display("FAIL clamp_ovf1_vec got=%b exp=%b", ovf1, exp_ovf(1)); end
  endtask

  task automatic test_same_edge();
    ch = 2; clr_ch = 1; in = 16'd4; load = 1; tick();
    ch = 2; in = 16'd9; load = 1; transf = 1; tick();
    rd_ch = 2; #0.5;
    checks += 2;
    if (out0 !== 16'd4) begin errors++; $display("FAIL same_edge_first0 got=%0d exp=4", out0); end
    if (out1 !== 16'd4) begin errors++; $display("FAIL same_edge_first1 got=%0d exp=4", out1); end
    ch = 2; transf = 1; tick();
    rd_ch = 2; #0.5;
    checks += 2;
    if (out0 !== 16'd13) begin errors++; $display("FAIL same_edge_next0 got=%0d exp=13", out0); end
    if (out1 !== 16'd13) begin errors++; $display("FAIL same_edge_next1 got=%0d exp=13", out1); end
  endtask

  task automatic test_clr_priority();
    ch = 3; clr_ch = 1; in = 16'd7; load = 1; tick();
    ch = 3; transf = 1; tick();
    rd_ch = 3; #0.5;
    checks += 4;
    if (out0 !== 16'd7) begin errors++; $display("FAIL clr_setup_out0 got=%0d exp=7", out0); end
    if (done0 !== 1'b1) begin errors++; $display("FAIL clr_setup_done0 got=%b exp=1", done0); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL oor_done1 got=%b exp=0", done1); end
    if (out1 !== 16'd0) begin errors++; $display("FAIL oor_out1 got=%h exp=0000", out1); end
    ch = 3; clr_ch = 1; transf = 1; tick();
    rd_ch = 3; #0.5;
    checks += 4;
    if (out0 !== 16'd0) begin errors++; $display("FAIL clr_prio_out0 got=%0d exp=0", out0); end
    if (ovf0[3] !== 1'b0) begin errors++; $display("FAIL clr_prio_ovf0 got=%b exp=0", ovf0[3]); end
    if (done0 !== 1'b0) begin errors++; $display("FAIL clr_prio_done0 got=%b exp=0", done0); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL oor_clr_done1 got=%b exp=0", done1); end
    for (int rd = 0; rd < 4; rd++) begin
      rd_ch = 2'(rd); #0.5;
      checks += 2;
      if (out0 !== exp_out(0, rd)) begin errors++; $display("FAIL clr_sweep0[%0d] got=%h exp=%h", rd, out0, exp_out(0, rd)); end
      if (out1 !== exp_out(1, rd)) begin errors++; $display("FAIL oor_sweep1[%0d] got=%h exp=%h", rd, out1, exp_out(1, rd)); end
    end
    checks += 1;
    if ({1'b0, ovf1} !== exp_ovf(1)) begin errors++; $display("FAIL oor_ovf1 got=%b exp=%b", ovf1, exp_ovf(1)); end
  endtask

  task automatic test_clear();
    ch = 1; in = 16'h1234; load = 1; tick();
    ch = 1; transf = 1; tick();
    #2 clear = 0;
    #1;
    rd_ch = 1; #0.5;
    checks += 5;
    if (out0 !== 16'h0) begin errors++; $display("FAIL clear_out0 got=%h exp=0000", out0); end
    if (out1 !== 16'h0) begin errors++; $display("FAIL clear_out1 got=%h exp=0000", out1); end
    if (ovf0 !== 4'h0) begin errors++; $display("FAIL clear_ovf0 got=%b exp=0000", ovf0); end
    if (ovf1 !== 3'h0) begin errors++; $display("FAIL clear_ovf1 got=%b exp=000", ovf1); end
    if ({done1, done0} !== 2'b00) begin errors++; $display("FAIL clear_done got=%b%b exp=00", done1, done0); end
    model_reset();
    #0.5 clear = 1;
    ch = 1; transf = 1; tick();
    rd_ch = 1; #0.5;
    checks += 3;
    if (out0 !== 16'h0) begin errors++; $display("FAIL clear_after_out0 got=%h exp=0000", out0); end
    if (out1 !== 16'h0) begin errors++; $display("FAIL clear_after_out1 got=%h exp=0000", out1); end
    if ({done1, done0} !== 2'b11) begin errors++; $display("FAIL clear_after_done got=%b%b exp=11", done1, done0); end
  endtask

  task automatic test_random();
    int rd;
    for (int it = 0; it < 400; it++) begin
      ch     = 2'($urandom_range(0, 3));
      load   = ($urandom_range(0, 1) == 1);
      transf = ($urandom_range(0, 1) == 1);
      sub    = ($urandom_range(0, 1) == 1);
      clr_ch = ($urandom_range(0, 9) == 0);
      in     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF)) : 16'($urandom);
      rd     = $urandom_range(0, 3);
      rd_ch  = 2'(rd);
      tick();
      checks += 6;
      if (out0 !== exp_out(0, rd)) begin errors++; $display("FAIL rand_out0 it%0d rd%0d got=%h exp=%h", it, rd, out0, exp_out(0, rd)); end
      if (out1 !== exp_out(1, rd)) begin errors++; $display("FAIL rand_out1 it%0d rd%0d got=%h exp=%h", it, rd, out1, exp_out(1, rd)); end
      if (ovf0 !== exp_ovf(0)) begin errors++; $display("FAIL rand_ovf0 it%0d got=%b exp=%b", it, ovf0, exp_ovf(0)); end
      if ({1'b0, ovf1} !== exp_ovf(1)) begin errors++; $display("FAIL rand_ovf1 it%0d got=%b exp=%b", it, ovf1, exp_ovf(1)); end
      if (done0 !== m_done[0]) begin errors++; $display("FAIL rand_done0 it%0d got=%b exp=%b", it, done0, m_done[0]); end
      if (done1 !== m_done[1]) begin errors++; $display("FAIL rand_done1 it%0d got=%b exp=%b", it, done1, m_done[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_and_clamp();
    test_same_edge();
    test_clr_priority();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
